pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/stall controller for the pipelined MIPS core. Tracks in-flight destination
//  registers from ID to WB in a scoreboard and generates per-operand forwarding selects, load-use
//  stalls, branch flushes and memory-busy freezes. Sequences halt as a pipeline drain.
//  Generalises the core's fixed cache_done/jmp_freeze stalling to NUM_STAGES depth and NUM_SRC operands.
// PARAMETERS
//  NUM_STAGES  3  tracked stages after ID (0=EX, 1=MEM, ..., NUM_STAGES-1=WB)
//  NUM_SRC     2  source operands checked per ID instruction
//  REG_ADDR_W  5  register-number width
//  FWD_W       $clog2(NUM_STAGES+1)  forwarding-select width (derived, localparam)
// PORTS
//  clk          in   1                   clock; all state updates on posedge
//  reset        in   1                   synchronous, active-high
//  id_valid     in   1                   ID holds a real instruction
//  id_src_num   in   NUM_SRC*REG_ADDR_W  source register numbers
//  id_src_used  in   NUM_SRC             operand actually read
//  id_rd_num    in   REG_ADDR_W          destination register
//  id_rd_we     in   1                   instruction writes rd
//  id_is_load   in   1                   instruction is a load
//  id_halt      in   1                   instruction is syscall/halt
//  mem_busy     in   1                   cache not done; whole pipe frozen
//  br_taken     in   1                   branch/jump resolved taken in EX
//  stall_if     out  1                   hold PC
//  stall_id     out  1                   hold IF/ID register
//  bubble_ex    out  1                   load NOP into ID/EX
//  flush_id     out  1                   squash IF/ID contents
//  fwd_sel      out  NUM_SRC*FWD_W       0=regfile, k+1=stage k result
//  halted       out  1                   registered; core stopped
//  stat_stalls  out  32                  load-use stall cycles (see CONFIGURATION)
//  stat_flushes out  32                  taken-branch flushes (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: scoreboard entries invalid, FSM=RUN, halted=0, stats=0. Combinational outputs reflect the
//    empty scoreboard: fwd_sel=0 and stall/bubble/flush low unless mem_busy or br_taken is asserted.
//  - Scoreboard entry {valid, rd, we, is_load, halt}. Shifts one stage per cycle when !mem_busy.
//    Entry 0 receives the ID instruction, or an invalid entry on bubble/flush/DRAIN.
//    The entry leaving NUM_STAGES-1 retires.
//  - Match(src,k) = id_src_used & valid_k & we_k & rd_k==src & rd_k!=0. Register 0 never matches.
//  - fwd_sel = youngest (lowest k) matching stage + 1, else 0. Combinational, zero latency.
//  - Load-use: youngest match is stage 0 with is_load. Then stall_if=stall_id=bubble_ex=1 for
//    exactly 1 cycle; the following cycle the match is at stage 1 and fwd_sel=2.
//  - Priority, highest first: mem_busy > br_taken > load-use.
//    mem_busy: stall_if=stall_id=1, bubble_ex=0, flush_id=0, scoreboard and FSM hold.
//    br_taken (sampled only when !mem_busy): flush_id=1, bubble_ex=1, stall_id=0; load-use suppressed.
//  - FSM RUN->DRAIN: a valid id_halt shifts into entry 0 with no flush.
//    In DRAIN, stall_if=stall_id=1 and bubbles are inserted.
//  - FSM DRAIN->HALTED: the halt entry retires from NUM_STAGES-1, giving NUM_STAGES cycles of DRAIN.
//    halted=1 from the next cycle; all stalls stay high until reset.
//  - A halt flushed by br_taken is never accepted. Reset in any state, including mid-drain, returns to RUN.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stat_stalls counts load-use stall cycles and stat_flushes counts
//    br_taken flushes. Both are 32-bit saturating, cleared on reset, frozen while mem_busy.
//  HAZARD_STATS_EN undefined: ports present, tied to 0, no counter flops.
// STRUCTURE
//  hazard_pkg: sb_entry_t struct, hz_state_e {RUN, DRAIN, HALTED}, fwd_w(n) function.
//  Sub-module hazard_scoreboard: parametrised shift register with hold/insert-invalid controls and
//    per-stage match outputs. Priority, forwarding and FSM logic stay in pipe_hazard_ctrl.
// TESTING
//  1 add r3 then add using r3 as src0 -> fwd_sel[0]=1, no stall.
//  2 lw r5 then add using r5 -> cycle1 stall_id=bubble_ex=1; cycle2 fwd_sel=2, stall_id=0.
//  3 mem_busy held 4 cycles over a load-use pair -> stall_id=1 and bubble_ex=0 throughout;
//    one bubble after release.
//  4 br_taken while ID has a load-use hazard -> flush_id=1, stall_id=0; stat_flushes +1 with macro.
//  5 producer writes r0, consumer reads r0 -> fwd_sel=0, no stall.
//  6 halt with NUM_STAGES=3 -> DRAIN 3 cycles, halted=1 on cycle 4.
//    Reset during DRAIN -> RUN, halted=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard entry, FSM state, fwd-select width.
package hazard_pkg;

  // Scoreboard rd field is sized for the widest register file we support (REG_ADDR_W <= 8).
  localparam int unsigned SbRdW = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic             valid;
    logic [SbRdW-1:0] rd;
    logic             we;
    logic             is_load;
    logic             halt;
  } sb_entry_t;

  function automatic int unsigned fwd_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard: one entry per tracked stage, shifted when not held,
// with per-operand/per-stage match flags against the ID sources.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_shift,
  input  sb_entry_t                     i_entry,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_src_num,
  input  logic [NUM_SRC-1:0]            i_src_used,
  output logic [NUM_SRC*NUM_STAGES-1:0] o_match,
  output logic                          o_head_is_load,
  output logic                          o_tail_halt
);

  sb_entry_t r_sb [NUM_STAGES];
  logic      w_unused_tail;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        r_sb[k] <= '0;
      end
    end else if (i_shift) begin
      r_sb[0] <= i_entry;
      for (int k = 1; k < NUM_STAGES; k++) begin
        r_sb[k] <= r_sb[k-1];
      end
    end
  end

  // Match flags are laid out source-major: bit s*NUM_STAGES+k is source s against stage k.
  always_comb begin
    o_match = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        o_match[s*NUM_STAGES+k] = i_src_used[s] & r_sb[k].valid & r_sb[k].we
            & (r_sb[k].rd == SbRdW'(i_src_num[s*REG_ADDR_W +: REG_ADDR_W]))
            & (r_sb[k].rd != '0);
      end
    end
  end

  assign o_head_is_load = r_sb[0].valid & r_sb[0].is_load;
  assign o_tail_halt    = r_sb[NUM_STAGES-1].valid & r_sb[NUM_STAGES-1].halt;
  assign w_unused_tail  = r_sb[NUM_STAGES-1].is_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: forwarding selects, load-use stall, branch flush, mem-busy freeze and
// halt drain. Optional build macro HAZARD_STATS_EN enables the stall/flush statistics counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] i_id_src_num,
  input  logic [NUM_SRC-1:0]            i_id_src_used,
  input  logic [REG_ADDR_W-1:0]         i_id_rd_num,
  input  logic                          i_id_rd_we,
  input  logic                          i_id_is_load,
  input  logic                          i_id_halt,
  input  logic                          i_mem_busy,
  input  logic                          i_br_taken,
  output logic                          o_stall_if,
  output logic                          o_stall_id,
  output logic                          o_bubble_ex,
  output logic                          o_flush_id,
  output logic [NUM_SRC*fwd_w(NUM_STAGES)-1:0] o_fwd_sel,
  output logic                          o_halted,
  output logic [31:0]                   o_stat_stalls,
  output logic [31:0]                   o_stat_flushes
);

  localparam int unsigned FWD_W = fwd_w(NUM_STAGES);

  hz_state_e                     r_state;
  logic                          r_halted;
  logic [NUM_SRC*NUM_STAGES-1:0] w_match;
  logic                          w_head_is_load;
  logic                          w_tail_halt;
  logic                          w_load_use;
  logic                          w_accept_halt;
  logic                          w_stall_ev;
  logic                          w_flush_ev;
  sb_entry_t                     w_entry;

  hazard_scoreboard #(
    .NUM_STAGES (NUM_STAGES),
    .NUM_SRC    (NUM_SRC),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_scoreboard (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_shift        (!i_mem_busy),
    .i_entry        (w_entry),
    .i_src_num      (i_id_src_num),
    .i_src_used     (i_id_src_used),
    .o_match        (w_match),
    .o_head_is_load (w_head_is_load),
    .o_tail_halt    (w_tail_halt)
  );

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    o_fwd_sel  = '0;
    w_load_use = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (w_match[s*NUM_STAGES+k]) begin
          o_fwd_sel[s*FWD_W +: FWD_W] = FWD_W'(k + 1);
        end
      end
      if (w_match[s*NUM_STAGES] && w_head_is_load) begin
        w_load_use = 1'b1;
      end
    end
  end

  always_comb begin
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_id    = 1'b0;
    w_accept_halt = 1'b0;
    w_stall_ev    = 1'b0;
    w_flush_ev    = 1'b0;
    w_entry       = '0;
    if (r_state == HALTED) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_bubble_ex = !i_mem_busy;
    end else if (i_mem_busy) begin
      o_stall_if = 1'b1;
      o_stall_id = 1'b1;
    end else if (r_state == DRAIN) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_bubble_ex = 1'b1;
    end else if (i_br_taken) begin
      o_flush_id  = 1'b1;
      o_bubble_ex = 1'b1;
      w_flush_ev  = 1'b1;
    end else if (w_load_use) begin
      o_stall_if  = 1'b1;
      o_stall_id  = 1'b1;
      o_bubble_ex = 1'b1;
      w_stall_ev  = 1'b1;
    end else begin
      w_entry.valid   = i_id_valid;
      w_entry.rd      = SbRdW'(i_id_rd_num);
      w_entry.we      = i_id_rd_we;
      w_entry.is_load = i_id_is_load;
      w_entry.halt    = i_id_valid & i_id_halt;
      w_accept_halt   = i_id_valid & i_id_halt;
    end
  end

  // The whole FSM freezes with the pipe while memory is busy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else if (!i_mem_busy) begin
      unique case (r_state)
        RUN: begin
          if (w_accept_halt) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_tail_halt) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        HALTED: begin
          r_halted <= 1'b1;
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  assign o_halted = r_halted;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stalls;
  logic [31:0] r_stat_flushes;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stat_stalls  <= '0;
      r_stat_flushes <= '0;
    end else begin
      if (w_stall_ev && (r_stat_stalls != '1)) r_stat_stalls <= r_stat_stalls + 32'd1;
      if (w_flush_ev && (r_stat_flushes != '1)) r_stat_flushes <= r_stat_flushes + 32'd1;
    end
  end

  assign o_stat_stalls  = r_stat_stalls;
  assign o_stat_flushes = r_stat_flushes;
`else
  logic w_unused_stats;

  assign w_unused_stats = w_stall_ev ^ w_flush_ev;
  assign o_stat_stalls  = '0;
  assign o_stat_flushes = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic against an in-order
// pipeline model that tracks instructions by age.
module tb_pipe_hazard_ctrl;

  localparam int NS   = 3;
  localparam int NSRC = 2;
  localparam int RW   = 5;
  localparam int FW   = $clog2(NS + 1);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 id_valid = 1'b0;
  logic [NSRC*RW-1:0]   id_src_num = '0;
  logic [NSRC-1:0]      id_src_used = '0;
  logic [RW-1:0]        id_rd_num = '0;
  logic                 id_rd_we = 1'b0;
  logic                 id_is_load = 1'b0;
  logic                 id_halt = 1'b0;
  logic                 mem_busy = 1'b0;
  logic                 br_taken = 1'b0;
  logic                 stall_if, stall_id, bubble_ex, flush_id, halted;
  logic [NSRC*FW-1:0]   fwd_sel;
  logic [31:0]          stat_stalls, stat_flushes;

  pipe_hazard_ctrl #(
    .NUM_STAGES (NS),
    .NUM_SRC    (NSRC),
    .REG_ADDR_W (RW)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_id_valid     (id_valid),
    .i_id_src_num   (id_src_num),
    .i_id_src_used  (id_src_used),
    .i_id_rd_num    (id_rd_num),
    .i_id_rd_we     (id_rd_we),
    .i_id_is_load   (id_is_load),
    .i_id_halt      (id_halt),
    .i_mem_busy     (mem_busy),
    .i_br_taken     (br_taken),
    .o_stall_if     (stall_if),
    .o_stall_id     (stall_id),
    .o_bubble_ex    (bubble_ex),
    .o_flush_id     (flush_id),
    .o_fwd_sel      (fwd_sel),
    .o_halted       (halted),
    .o_stat_stalls  (stat_stalls),
    .o_stat_flushes (stat_flushes)
  );

  always #5 clk = ~clk;

  // Model: in-flight instructions indexed by age (0 = just left ID).
  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit ld;
  } ins_t;

  ins_t pipe [NS];
  bit   m_drain, m_halted;
  int   m_dcnt, m_stalls, m_flushes;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic [NSRC*FW-1:0] e_fwd;
  bit e_lu, e_sif, e_sid, e_bub, e_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NS; k++) pipe[k] = '{valid: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    m_drain = 1'b0;
    m_halted = 1'b0;
    m_dcnt = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  task automatic model_eval();
    e_fwd = '0;
    e_lu = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      int src = int'(id_src_num[s*RW +: RW]);
      int age = 0;
      for (int k = 0; k < NS; k++) begin
        if (age == 0 && id_src_used[s] && src != 0 && pipe[k].valid && pipe[k].we &&
            pipe[k].rd == src) age = k + 1;
      end
      e_fwd[s*FW +: FW] = FW'(age);
      if (age == 1 && pipe[0].ld) e_lu = 1'b1;
    end
    {e_sif, e_sid, e_bub, e_fl} = 4'b0000;
    if (m_halted)      {e_sif, e_sid, e_bub, e_fl} = {2'b11, !mem_busy, 1'b0};
    else if (mem_busy) {e_sif, e_sid, e_bub, e_fl} = 4'b1100;
    else if (m_drain)  {e_sif, e_sid, e_bub, e_fl} = 4'b1110;
    else if (br_taken) {e_sif, e_sid, e_bub, e_fl} = 4'b0011;
    else if (e_lu)     {e_sif, e_sid, e_bub, e_fl} = 4'b1110;
  endtask

  task automatic model_advance();
    ins_t nw;
    bit   take;
    if (mem_busy) return;
    nw = '{valid: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
    take = !m_halted && !m_drain && !br_taken && !e_lu;
    if (!m_halted && !m_drain && br_taken) m_flushes++;
    if (!m_halted && !m_drain && !br_taken && e_lu) m_stalls++;
    if (take && id_valid) nw = '{valid: 1'b1, rd: int'(id_rd_num), we: id_rd_we, ld: id_is_load};
    for (int k = NS - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = nw;
    if (m_drain) begin
      m_dcnt++;
      if (m_dcnt == NS) begin
        m_drain = 1'b0;
        m_halted = 1'b1;
      end
    end else if (take && id_valid && id_halt) begin
      m_drain = 1'b1;
      m_dcnt = 0;
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("stall_if", 64'(stall_if), 64'(e_sif));
    chk("stall_id", 64'(stall_id), 64'(e_sid));
    chk("bubble_ex", 64'(bubble_ex), 64'(e_bub));
    chk("flush_id", 64'(flush_id), 64'(e_fl));
    chk("fwd_sel", 64'(fwd_sel), 64'(e_fwd));
    chk("halted", 64'(halted), 64'(m_halted));
`ifdef HAZARD_STATS_EN
    chk("stat_stalls", 64'(stat_stalls), 64'(m_stalls));
    chk("stat_flushes", 64'(stat_flushes), 64'(m_flushes));
`else
    chk("stat_stalls", 64'(stat_stalls), 64'd0);
    chk("stat_flushes", 64'(stat_flushes), 64'd0);
`endif
  endtask

  task automatic apply(input bit v, input int s0, input int s1, input bit [1:0] used,
                       input int rd, input bit we, input bit ld, input bit hl,
                       input bit busy, input bit br);
    @(negedge clk);
    id_valid    = v;
    id_src_num  = {RW'(s1), RW'(s0)};
    id_src_used = used;
    id_rd_num   = RW'(rd);
    id_rd_we    = we;
    id_is_load  = ld;
    id_halt     = hl;
    mem_busy    = busy;
    br_taken    = br;
    #1;
    check_all();
    model_advance();
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input bit busy, input bit br);
    apply(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0, busy, br);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {id_valid, id_rd_we, id_is_load, id_halt, mem_busy, br_taken} = '0;
    id_src_used = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cyc++;
  endtask

  initial begin
    model_reset();
    do_reset();
    // Reset state, then the freeze/flush overrides on an empty scoreboard.
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b1);

    // Plain forward: add r3 then consumer of r3.
    apply(1'b1, 1, 2, 2'b11, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 3, 0, 2'b01, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load-use: lw r5, add uses r5 (stall, then forward from stage 1).
    apply(1'b1, 1, 1, 2'b00, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 5, 0, 2'b01, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 5, 0, 2'b01, 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // mem_busy held over a load-use pair.
    apply(1'b1, 0, 0, 2'b00, 6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b1, 0, 6, 2'b10, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 0, 6, 2'b10, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 0, 6, 2'b10, 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch taken beats a pending load-use.
    apply(1'b1, 0, 0, 2'b00, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 7, 7, 2'b11, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Register 0 never forwards or stalls.
    apply(1'b1, 0, 0, 2'b00, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 0, 0, 2'b11, 9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt drain, hold in HALTED, then reset.
    apply(1'b1, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b1, 1'b0);
    do_reset();
    idle(1'b0, 1'b0);

    // Reset in the middle of a drain; then a halt flushed by a branch.
    apply(1'b1, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    do_reset();
    idle(1'b0, 1'b0);
    apply(1'b1, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);

    // Random traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2 || (m_halted && $urandom_range(0, 3) == 0)) begin
        do_reset();
      end else begin
        apply($urandom_range(0, 9) < 8, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
